// File: rtl/ahb_decoder_mux.sv
// AHB-Lite decoder and response mux. Registered data-phase select, a two-cycle ERROR
// default subordinate, and a per-port stall watchdog that locks out hung subordinates.

module ahb_dec_port #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE           = '0,
  parameter logic [ADDR_WIDTH-1:0] SIZE           = '0,
  parameter int                    TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  sel,
  input  logic                  ready,
  output logic                  hit,
  output logic                  hung,
  output logic                  expire
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] MASK  = ~(SIZE - ADDR_WIDTH'(1));
  localparam logic [CW-1:0]         LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign hit    = (addr & MASK) == BASE;
  // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle of this port's data phase.
  assign expire = (TIMEOUT_CYCLES > 0) && sel && !ready && (cnt == LIMIT);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      hung <= 1'b0;
    end else begin
      if (expire) hung <= 1'b1;
      if (sel && !ready && !expire) cnt <= cnt + 1'b1;
      else                          cnt <= '0;
    end
endmodule

module ahb_decoder_mux #(
  parameter int                              DATA_WIDTH     = 32,
  parameter int                              ADDR_WIDTH     = 32,
  parameter int                              NUM_PORTS      = 8,
  parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] BASE_ADDRS     = '0,
  parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] SIZES          = {NUM_PORTS{ADDR_WIDTH'(32'h0010_0000)}},
  parameter int                              TIMEOUT_CYCLES = 256,
  parameter bit                              DEBUG_RAZ      = 1'b1
) (
  input  logic                            HCLK,
  input  logic                            HRESETn,
  input  logic                            S_HSEL,
  input  logic [ADDR_WIDTH-1:0]           S_HADDR,
  input  logic                            S_HWRITE,
  input  logic [2:0]                      S_HSIZE,
  input  logic [2:0]                      S_HBURST,
  input  logic [3:0]                      S_HPROT,
  input  logic [1:0]                      S_HTRANS,
  input  logic                            S_HMASTLOCK,
  input  logic [DATA_WIDTH-1:0]           S_HWDATA,
  input  logic                            S_HMASTER,
  output logic                            S_HREADY,
  output logic                            S_HRESP,
  output logic [DATA_WIDTH-1:0]           S_HRDATA,
  output logic [NUM_PORTS-1:0]            M_HSEL,
  output logic [ADDR_WIDTH-1:0]           M_HADDR,
  output logic                            M_HWRITE,
  output logic [2:0]                      M_HSIZE,
  output logic [2:0]                      M_HBURST,
  output logic [3:0]                      M_HPROT,
  output logic [1:0]                      M_HTRANS,
  output logic                            M_HMASTLOCK,
  output logic [DATA_WIDTH-1:0]           M_HWDATA,
  output logic                            M_HREADY,
  input  logic [NUM_PORTS-1:0]            M_HREADYOUT,
  input  logic [NUM_PORTS-1:0]            M_HRESP,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] M_HRDATA,
  output logic [NUM_PORTS-1:0]            HUNG
);
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_e;

  ds_e                  ds, ds_nxt;
  logic [NUM_PORTS-1:0] hit, first_hit, hung, expire, tgt_oh, dsel_oh;
  logic                 valid, tgt_def, tgt_raz, dsel_def, dsel_raz, expire_any, found;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    ahb_dec_port #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .BASE           (BASE_ADDRS[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .SIZE           (SIZES[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_port (
      .clk    (HCLK),
      .rst_n  (HRESETn),
      .addr   (S_HADDR),
      .sel    (dsel_oh[i]),
      .ready  (M_HREADYOUT[i]),
      .hit    (hit[i]),
      .hung   (hung[i]),
      .expire (expire[i])
    );
  end

  always_comb begin
    first_hit = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      first_hit[k] = hit[k] && !found;
      found        = found || hit[k];
    end
  end

  // A hung lowest-index hit still owns the address; it falls to the ERROR path, not a higher port.
  assign valid      = S_HSEL && S_HTRANS[1];
  assign M_HSEL     = {NUM_PORTS{S_HSEL}} & first_hit & ~hung;
  assign tgt_oh     = valid ? (first_hit & ~hung) : '0;
  assign tgt_raz    = valid && (hit == '0) && DEBUG_RAZ && S_HMASTER;
  assign tgt_def    = valid && (tgt_oh == '0) && !tgt_raz;
  assign expire_any = |expire;

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      dsel_oh  <= '0;
      dsel_def <= 1'b0;
      dsel_raz <= 1'b0;
    end else if (expire_any) begin
      dsel_oh  <= '0;
      dsel_def <= 1'b1;
      dsel_raz <= 1'b0;
    end else if (S_HREADY) begin
      dsel_oh  <= tgt_oh;
      dsel_def <= tgt_def;
      dsel_raz <= tgt_raz;
    end

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) ds <= DS_IDLE;
    else          ds <= ds_nxt;

  always_comb begin
    ds_nxt = ds;
    case (ds)
      DS_IDLE: if ((S_HREADY && tgt_def) || expire_any) ds_nxt = DS_ERR1;
      DS_ERR1: ds_nxt = DS_ERR2;
      DS_ERR2: ds_nxt = tgt_def ? DS_ERR1 : DS_IDLE;
      default: ds_nxt = DS_IDLE;
    endcase
  end

  // none and DEBUG_RAZ both fall through to 1/OKAY/0 since no dsel_oh bit is set.
  always_comb begin
    S_HREADY = ~|(dsel_oh & ~M_HREADYOUT);
    S_HRESP  = |(dsel_oh & M_HRESP);
    S_HRDATA = '0;
    for (int k = 0; k < NUM_PORTS; k++)
      if (dsel_oh[k]) S_HRDATA = M_HRDATA[k*DATA_WIDTH +: DATA_WIDTH];
    if (dsel_def) begin
      S_HREADY = (ds == DS_ERR2);
      S_HRESP  = 1'b1;
    end
  end

  assign M_HADDR     = S_HADDR;
  assign M_HWRITE    = S_HWRITE;
  assign M_HSIZE     = S_HSIZE;
  assign M_HBURST    = S_HBURST;
  assign M_HPROT     = S_HPROT;
  assign M_HTRANS    = S_HTRANS;
  assign M_HMASTLOCK = S_HMASTLOCK;
  assign M_HWDATA    = S_HWDATA;
  assign M_HREADY    = S_HREADY;
  assign HUNG        = hung;
endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Bench for ahb_decoder_mux: directed and random transfer streams against a
// transaction-level model of the address map, wait states, ERROR and watchdog rules.

module tb_ahb_decoder_mux;
  localparam int NP = 4;
  localparam int TO = 16;
  localparam logic [31:0] BASE_T [NP] = '{32'h0000_0000, 32'h4000_0000, 32'h2000_0000, 32'h4000_0000};
  localparam logic [31:0] SIZE_T [NP] = '{32'h0010_0000, 32'h0000_1000, 32'h0001_0000, 32'h0010_0000};
  localparam logic [NP*32-1:0] BASES_P = {BASE_T[3], BASE_T[2], BASE_T[1], BASE_T[0]};
  localparam logic [NP*32-1:0] SIZES_P = {SIZE_T[3], SIZE_T[2], SIZE_T[1], SIZE_T[0]};

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic        master;
    logic        hsel;
    logic [1:0]  trans;
    int          waits;
    logic        err;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    int          cycles;
    logic        resp;
    logic [31:0] rdata;
  } exp_t;

  logic HCLK, HRESETn;
  logic S_HSEL, S_HWRITE, S_HMASTLOCK, S_HMASTER, S_HREADY, S_HRESP;
  logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
  logic [2:0] S_HSIZE, S_HBURST;
  logic [3:0] S_HPROT;
  logic [1:0] S_HTRANS;
  logic [NP-1:0] M_HSEL, M_HREADYOUT, M_HRESP, HUNG;
  logic [31:0] M_HADDR, M_HWDATA;
  logic M_HWRITE, M_HMASTLOCK, M_HREADY;
  logic [2:0] M_HSIZE, M_HBURST;
  logic [3:0] M_HPROT;
  logic [1:0] M_HTRANS;
  logic [NP*32-1:0] M_HRDATA;

  int checks = 0, failures = 0;
  logic [NP-1:0] model_hung;
  txn_t txq[$];

  // what the subordinate that captures the current address phase will do
  int ap_waits;
  logic ap_err;
  logic [31:0] ap_data;

  int          sub_rem  [NP];
  logic        sub_busy [NP];
  logic        sub_err  [NP];
  logic        sub_e2   [NP];
  logic [31:0] sub_data [NP];

  ahb_decoder_mux #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_PORTS(NP), .BASE_ADDRS(BASES_P),
    .SIZES(SIZES_P), .TIMEOUT_CYCLES(TO), .DEBUG_RAZ(1'b1)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE),
    .S_HBURST(S_HBURST), .S_HPROT(S_HPROT), .S_HTRANS(S_HTRANS), .S_HMASTLOCK(S_HMASTLOCK),
    .S_HWDATA(S_HWDATA), .S_HMASTER(S_HMASTER), .S_HREADY(S_HREADY), .S_HRESP(S_HRESP),
    .S_HRDATA(S_HRDATA), .M_HSEL(M_HSEL), .M_HADDR(M_HADDR), .M_HWRITE(M_HWRITE),
    .M_HSIZE(M_HSIZE), .M_HBURST(M_HBURST), .M_HPROT(M_HPROT), .M_HTRANS(M_HTRANS),
    .M_HMASTLOCK(M_HMASTLOCK), .M_HWDATA(M_HWDATA), .M_HREADY(M_HREADY),
    .M_HREADYOUT(M_HREADYOUT), .M_HRESP(M_HRESP), .M_HRDATA(M_HRDATA), .HUNG(HUNG)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // subordinate models: waits, then optional two-cycle ERROR; idle ports drive junk read data
  always @(posedge HCLK or negedge HRESETn)
    for (int i = 0; i < NP; i++)
      if (!HRESETn) begin
        sub_busy[i] <= 1'b0;
        sub_rem[i]  <= 0;
        sub_err[i]  <= 1'b0;
        sub_e2[i]   <= 1'b0;
        sub_data[i] <= '0;
      end else begin
        if (sub_busy[i]) begin
          if (sub_rem[i] > 0)                sub_rem[i]  <= sub_rem[i] - 1;
          else if (sub_err[i] && !sub_e2[i]) sub_e2[i]   <= 1'b1;
          else                               sub_busy[i] <= 1'b0;
        end
        if (M_HSEL[i] && M_HTRANS[1] && M_HREADY) begin
          sub_busy[i] <= 1'b1;
          sub_rem[i]  <= ap_waits;
          sub_err[i]  <= ap_err;
          sub_e2[i]   <= 1'b0;
          sub_data[i] <= ap_data;
        end
      end

  always_comb begin
    M_HREADYOUT = '1;
    M_HRESP     = '0;
    M_HRDATA    = '0;
    for (int i = 0; i < NP; i++) begin
      M_HRDATA[i*32 +: 32] = sub_busy[i] ? sub_data[i] : (32'hBAD0_0000 | i);
      if (sub_busy[i]) begin
        if (sub_rem[i] > 0) M_HREADYOUT[i] = 1'b0;
        else if (sub_err[i] && !sub_e2[i]) begin M_HREADYOUT[i] = 1'b0; M_HRESP[i] = 1'b1; end
        else M_HRESP[i] = sub_err[i];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NP; i++)
      if (64'(a) >= 64'(BASE_T[i]) && 64'(a) < 64'(BASE_T[i]) + 64'(SIZE_T[i])) return i;
    return -1;
  endfunction

  function automatic logic [NP-1:0] exp_msel(input txn_t t);
    int p = decode(t.addr);
    if (!t.hsel || p < 0 || model_hung[p]) return '0;
    return NP'(1) << p;
  endfunction

  task automatic predict(input txn_t t, output exp_t e);
    int p, l;
    p = decode(t.addr);
    e.cycles = 1; e.resp = 1'b0; e.rdata = '0;
    if (!(t.hsel && t.trans[1])) return;
    if (p < 0 && t.master) return;
    if (p < 0 || model_hung[p]) begin e.cycles = 2; e.resp = 1'b1; return; end
    l = t.waits + int'(t.err);
    if (l >= TO) begin
      model_hung[p] = 1'b1;
      e.cycles = TO + 2; e.resp = 1'b1;
      return;
    end
    e.cycles = l + 1; e.resp = t.err; e.rdata = t.data;
  endtask

  function automatic txn_t mk(input logic [31:0] a, input logic w, input logic m,
                              input int waits, input logic err, input logic [31:0] d);
    txn_t t;
    t.addr = a; t.write = w; t.master = m; t.hsel = 1'b1; t.trans = 2'b10;
    t.waits = waits; t.err = err; t.data = d;
    return t;
  endfunction

  task automatic drive(input txn_t t);
    S_HSEL = t.hsel; S_HADDR = t.addr; S_HWRITE = t.write; S_HTRANS = t.trans;
    S_HMASTER = t.master; ap_waits = t.waits; ap_err = t.err; ap_data = t.data;
    S_HWDATA = $urandom;
  endtask

  task automatic drive_idle();
    S_HSEL = 1'b0; S_HTRANS = 2'b00; S_HADDR = $urandom; S_HWRITE = 1'b0; S_HMASTER = 1'b0;
    ap_waits = 0; ap_err = 1'b0; ap_data = '0;
  endtask

  // AHB manager: overlaps each address phase with the previous data phase
  task automatic run_q();
    int n = txq.size();
    int ap = 0, dp = -1, cyc = 0, guard = 0;
    logic rdy, prev_rdy = 1'b1, prev_resp = 1'b0;
    exp_t e;
    e.cycles = 0; e.resp = 1'b0; e.rdata = '0;
    while ((ap < n || dp >= 0) && guard < 5000) begin
      if (ap < n) drive(txq[ap]);
      else        drive_idle();
      @(negedge HCLK);
      guard++;
      rdy = S_HREADY;
      if (dp >= 0) begin
        cyc++;
        if (rdy) begin
          chk("latency", 64'(cyc), 64'(e.cycles));
          chk("hresp", 64'(S_HRESP), 64'(e.resp));
          if (e.resp) chk("err_first_cycle", {62'd0, prev_rdy, prev_resp}, 64'b01);
          else if (!txq[dp].write) chk("hrdata", 64'(S_HRDATA), 64'(e.rdata));
          chk("hung", 64'(HUNG), 64'(model_hung));
        end
        prev_rdy = S_HREADY; prev_resp = S_HRESP;
      end
      if (rdy && ap < n) begin
        chk("m_hsel", 64'(M_HSEL), 64'(exp_msel(txq[ap])));
        chk("m_haddr", 64'(M_HADDR), 64'(txq[ap].addr));
      end
      @(posedge HCLK);
      #1;
      if (rdy) begin
        if (ap < n) begin predict(txq[ap], e); dp = ap; ap++; cyc = 0; end
        else dp = -1;
      end
    end
    if (guard >= 5000) chk("stream_timeout", 64'(guard), 64'd0);
    drive_idle();
    txq = {};
  endtask

  task automatic add_rand();
    txn_t t;
    int c = $urandom_range(0, 9);
    int r;
    logic [31:0] bnd [9] = '{32'h000F_FFFC, 32'h0010_0000, 32'h4000_0FFC, 32'h4000_1000,
                             32'h2000_FFFC, 32'h2001_0000, 32'h400F_FFFC, 32'h4010_0000, 32'h1FFF_FFFC};
    t = mk(32'h0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 4),
           ($urandom_range(0, 5) == 0), $urandom);
    case (c)
      0, 1:    t.addr = $urandom_range(0, 32'h000F_FFFF) & ~32'h3;
      2, 3:    t.addr = 32'h4000_0000 | ($urandom_range(0, 32'hFFF) & ~32'h3);
      4:       t.addr = 32'h2000_0000 | ($urandom_range(0, 32'hFFFF) & ~32'h3);
      5:       t.addr = 32'h4000_1000 + ($urandom_range(0, 32'hFEFFF) & ~32'h3);
      6, 7:    t.addr = 32'h8000_0000 | ($urandom & ~32'h3);
      default: t.addr = bnd[$urandom_range(0, 8)];
    endcase
    t.hsel = ($urandom_range(0, 9) != 0);
    r = $urandom_range(0, 9);
    t.trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r == 2) ? 2'b11 : 2'b10;
    txq.push_back(t);
  endtask

  initial begin
    HRESETn = 1'b0; model_hung = '0;
    S_HSIZE = 3'b010; S_HBURST = 3'b000; S_HPROT = 4'b0011; S_HMASTLOCK = 1'b0; S_HWDATA = '0;
    drive_idle();
    #1;
    chk("rst_hready", 64'(S_HREADY), 64'd1);
    chk("rst_hresp", 64'(S_HRESP), 64'd0);
    chk("rst_hrdata", 64'(S_HRDATA), 64'd0);
    chk("rst_hung", 64'(HUNG), 64'd0);
    chk("rst_msel", 64'(M_HSEL), 64'd0);
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;

    // port1 read, one wait state
    txq.push_back(mk(32'h4000_0010, 1'b0, 1'b0, 1, 1'b0, 32'hDEAD_BEEF));
    run_q();
    // pipelined port0 -> port1
    txq.push_back(mk(32'h0000_0004, 1'b0, 1'b0, 2, 1'b0, 32'h1111_1111));
    txq.push_back(mk(32'h4000_0000, 1'b0, 1'b0, 0, 1'b0, 32'h2222_2222));
    txq.push_back(mk(32'h4000_1000, 1'b0, 1'b0, 1, 1'b0, 32'h3333_3333));
    run_q();
    // unmapped: normal master, then debugger RAZ, then two back-to-back errors
    txq.push_back(mk(32'h8000_0000, 1'b0, 1'b0, 0, 1'b0, 32'h0));
    txq.push_back(mk(32'h8000_0000, 1'b0, 1'b1, 0, 1'b0, 32'h0));
    txq.push_back(mk(32'h8000_0000, 1'b0, 1'b0, 0, 1'b0, 32'h0));
    txq.push_back(mk(32'h8000_0100, 1'b0, 1'b0, 0, 1'b0, 32'h0));
    run_q();

    for (int i = 0; i < 300; i++) add_rand();
    run_q();

    // watchdog: port1 stalls well past the limit, then is locked out
    txq.push_back(mk(32'h4000_0020, 1'b0, 1'b0, 40, 1'b0, 32'h4444_4444));
    txq.push_back(mk(32'h4000_0000, 1'b0, 1'b0, 0, 1'b0, 32'h5555_5555));
    txq.push_back(mk(32'h4000_2000, 1'b0, 1'b0, 1, 1'b0, 32'h6666_6666));
    txq.push_back(mk(32'h4000_0010, 1'b0, 1'b1, 0, 1'b0, 32'h7777_7777));
    txq.push_back(mk(32'h0000_0100, 1'b0, 1'b0, 0, 1'b0, 32'h8888_8888));
    run_q();
    chk("hung1_sticky", 64'(HUNG), 64'b0010);

    // reset while the default subordinate is in its first ERROR cycle
    drive(mk(32'h8000_0000, 1'b0, 1'b0, 0, 1'b0, 32'h0));
    @(negedge HCLK);
    chk("pre_err_ready", 64'(S_HREADY), 64'd1);
    @(posedge HCLK);
    #1 drive_idle();
    @(negedge HCLK);
    chk("err1_state", {62'd0, S_HREADY, S_HRESP}, 64'b01);
    #2 HRESETn = 1'b0;
    #1;
    chk("async_rst_hready", 64'(S_HREADY), 64'd1);
    chk("async_rst_hresp", 64'(S_HRESP), 64'd0);
    chk("async_rst_hung", 64'(HUNG), 64'd0);
    model_hung = '0;
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    txq.push_back(mk(32'h4000_0010, 1'b0, 1'b0, 1, 1'b0, 32'hCAFE_F00D));
    txq.push_back(mk(32'h8000_0000, 1'b1, 1'b0, 0, 1'b0, 32'h0));
    run_q();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
